// File: rtl/cgra_ctrl_pkg.sv
// Shared types and defaults for the CGRA stream control unit.
package cgra_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        EXEC   = 2'd2
    } ctrl_state_e;

    localparam int unsigned CNT_W_DEFAULT     = 32;
    localparam int unsigned TIMEOUT_W_DEFAULT = 32;

endpackage

// File: rtl/cgra_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module cgra_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/cgra_stream_control_unit.sv
// CGRA execution controller: sequences config load and masked stream execution
// with watchdog, abort and saturating performance counters.
module cgra_stream_control_unit
    import cgra_ctrl_pkg::*;
#(
    parameter int unsigned N_IN      = 4,
    parameter int unsigned N_OUT     = 4,
    parameter int unsigned CNT_W     = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_execution_i,
    input  logic                 load_configuration_i,
    input  logic                 abort_i,
    input  logic                 clear_counters_i,
    input  logic [N_IN-1:0]      in_enable_mask_i,
    input  logic [N_OUT-1:0]     out_enable_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    input  logic                 data_config_done_i,
    input  logic [N_OUT-1:0]     data_output_done_i,
    input  logic                 data_read_stall_i,
    input  logic                 data_write_stall_i,
    output logic                 execute_config_o,
    output logic [N_IN-1:0]      execute_input_o,
    output logic [N_OUT-1:0]     execute_output_o,
    output logic                 busy_o,
    output logic                 done_config_o,
    output logic                 done_exec_o,
    output logic                 abort_o,
    output logic                 error_timeout_o,
    output logic [CNT_W-1:0]     cycle_count_load_config_o,
    output logic [CNT_W-1:0]     cycle_count_execute_o,
    output logic [CNT_W-1:0]     cycle_count_stall_o
);

    ctrl_state_e          state_q, state_d;
    logic [N_OUT-1:0]     pending_q, pending_d, pending_left;
    logic [TIMEOUT_W-1:0] wd_q;

    logic in_idle, in_cfg, in_exec, in_busy;
    logic launch_cfg, launch_exec;
    logic cfg_finish, exec_finish, complete;
    logic wd_hit, do_abort, do_timeout;

    logic             exec_cfg_d, done_cfg_d, done_exec_d, abort_d, err_d, busy_d;
    logic [N_IN-1:0]  exec_in_d;
    logic [N_OUT-1:0] exec_out_d;

    assign in_idle = (state_q == IDLE);
    assign in_cfg  = (state_q == CONFIG);
    assign in_exec = (state_q == EXEC);
    assign in_busy = in_cfg | in_exec;

    // Load has priority over start when both arrive in IDLE.
    assign launch_cfg  = in_idle & load_configuration_i;
    assign launch_exec = in_idle & start_execution_i & ~load_configuration_i;

    assign pending_left = pending_q & ~data_output_done_i;
    assign cfg_finish   = in_cfg & data_config_done_i;
    assign exec_finish  = in_exec & (pending_left == '0);
    assign complete     = cfg_finish | exec_finish;

    // Watchdog value counts the current cycle as wd_q+1.
    assign wd_hit     = in_busy & (timeout_cycles_i != '0) &
                        (wd_q == (timeout_cycles_i - TIMEOUT_W'(1)));
    assign do_abort   = in_busy & abort_i;
    assign do_timeout = wd_hit & ~complete & ~do_abort;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            pending_q        <= '0;
            execute_config_o <= 1'b0;
            execute_input_o  <= '0;
            execute_output_o <= '0;
            busy_o           <= 1'b0;
            done_config_o    <= 1'b0;
            done_exec_o      <= 1'b0;
            abort_o          <= 1'b0;
            error_timeout_o  <= 1'b0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            execute_config_o <= exec_cfg_d;
            execute_input_o  <= exec_in_d;
            execute_output_o <= exec_out_d;
            busy_o           <= busy_d;
            done_config_o    <= done_cfg_d;
            done_exec_o      <= done_exec_d;
            abort_o          <= abort_d;
            error_timeout_o  <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (load_configuration_i) begin
                    state_d = CONFIG;
                end else if (start_execution_i) begin
                    state_d   = EXEC;
                    pending_d = out_enable_mask_i;
                end
            end
            CONFIG, EXEC: begin
                if (in_exec)
                    pending_d = pending_left;
                if (do_abort || complete || wd_hit) begin
                    state_d   = IDLE;
                    pending_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_comb begin
        exec_cfg_d  = launch_cfg;
        exec_in_d   = launch_exec ? in_enable_mask_i  : '0;
        exec_out_d  = launch_exec ? out_enable_mask_i : '0;
        done_cfg_d  = cfg_finish & ~do_abort;
        done_exec_d = exec_finish & ~do_abort;
        abort_d     = do_abort | do_timeout;
        busy_d      = (state_d != IDLE);
        err_d       = error_timeout_o;
        if (launch_cfg || launch_exec)
            err_d = 1'b0;
        if (do_timeout)
            err_d = 1'b1;
    end

    cgra_sat_counter #(.W(CNT_W)) u_cnt_cfg (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clear_counters_i | launch_cfg),
        .inc (in_cfg),
        .q   (cycle_count_load_config_o)
    );

    cgra_sat_counter #(.W(CNT_W)) u_cnt_exec (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clear_counters_i | launch_exec),
        .inc (in_exec),
        .q   (cycle_count_execute_o)
    );

    cgra_sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk (clk_i),
        .rst (rst_i),
        .clr (clear_counters_i | launch_exec),
        .inc (in_exec & (data_read_stall_i | data_write_stall_i)),
        .q   (cycle_count_stall_o)
    );

    cgra_sat_counter #(.W(TIMEOUT_W)) u_watchdog (
        .clk (clk_i),
        .rst (rst_i),
        .clr (~in_busy),
        .inc (in_busy),
        .q   (wd_q)
    );

endmodule
